// File: rtl/mem_access_if.sv
// mem_access_if: request/response and memory-side bus bundle for mem_access_unit
// Request side:  req_valid/req_ready handshake, req_write, req_funct3, req_addr, req_wdata
// Response side: resp_valid pulse, resp_rdata, resp_error
// Memory side:   mem_read/mem_write strobes, mem_address, mem_wdata, mem_byte_enable, mem_rdata, mem_resp
// slave modport is the unit itself; master is the requester plus memory model
interface mem_access_if #(parameter int XLEN = 32);
  logic req_valid;
  logic req_ready;
  logic req_write;
  logic [2:0] req_funct3;
  logic [XLEN-1:0] req_addr;
  logic [XLEN-1:0] req_wdata;
  logic resp_valid;
  logic [XLEN-1:0] resp_rdata;
  logic [1:0] resp_error;
  logic mem_read;
  logic mem_write;
  logic [XLEN-1:0] mem_address;
  logic [XLEN-1:0] mem_wdata;
  logic [XLEN/8-1:0] mem_byte_enable;
  logic [XLEN-1:0] mem_rdata;
  logic mem_resp;
  modport master (
    output req_valid, req_write, req_funct3, req_addr, req_wdata, mem_rdata, mem_resp,
    input  req_ready, resp_valid, resp_rdata, resp_error,
    input  mem_read, mem_write, mem_address, mem_wdata, mem_byte_enable
  );
  modport slave (
    input  req_valid, req_write, req_funct3, req_addr, req_wdata, mem_rdata, mem_resp,
    output req_ready, resp_valid, resp_rdata, resp_error,
    output mem_read, mem_write, mem_address, mem_wdata, mem_byte_enable
  );
endinterface

// File: rtl/mem_access_unit.sv
// mem_access_unit: RISC-V style load/store unit with alignment/funct3 checks, lane steering and optional timeout
// Ports: clk (rising edge), rst (async active-high), bus (mem_access_if.slave: request, response and memory bus)
// Parameters: XLEN (32 or 64), TIMEOUT (max ACCESS cycles waiting for mem_resp, 0 = wait forever)
module mem_access_unit #(
  parameter int XLEN = 32,
  parameter int TIMEOUT = 0
) (
  input logic clk,
  input logic rst,
  mem_access_if.slave bus
);
  localparam int BW = XLEN / 8;
  localparam int OW = $clog2(BW);
  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
  state_t state, state_n;
  logic [2:0] f3_q;
  logic wr_q;
  logic [OW-1:0] off_q;
  logic [31:0] cnt;
  logic [1:0] sz;
  logic legal;
  logic misal;
  logic [1:0] err;
  logic timed_out;
  logic [BW-1:0] be_base;
  logic [XLEN-1:0] rep;
  logic [XLEN-1:0] shifted;
  logic [XLEN-1:0] ext;
  always_comb begin
    sz = bus.req_funct3[1:0];
    legal = bus.req_write
      ? !bus.req_funct3[2] && (sz != 2'd3 || XLEN == 64)
      : bus.req_funct3 != 3'b111 && ((bus.req_funct3 != 3'b011 && bus.req_funct3 != 3'b110) || XLEN == 64);
    misal = (bus.req_addr[2:0] & ((3'b001 << sz) - 3'b001)) != 3'b000;
    err = !legal ? 2'b10 : misal ? 2'b01 : 2'b00;
    be_base = sz == 2'd0 ? BW'(1) : sz == 2'd1 ? BW'(3) : sz == 2'd2 ? BW'(15) : BW'(255);
    rep = sz == 2'd0 ? {BW{bus.req_wdata[7:0]}}
        : sz == 2'd1 ? {(BW/2){bus.req_wdata[15:0]}}
        : sz == 2'd2 ? {(BW/4){bus.req_wdata[31:0]}} : bus.req_wdata;
    shifted = bus.mem_rdata >> {off_q, 3'b000};
    // funct3[2] selects zero extension; the size casts of signed slices sign-extend
    ext = f3_q == 3'b000 ? XLEN'($signed(shifted[7:0]))
        : f3_q == 3'b001 ? XLEN'($signed(shifted[15:0]))
        : f3_q == 3'b010 ? XLEN'($signed(shifted[31:0]))
        : f3_q == 3'b100 ? XLEN'(shifted[7:0])
        : f3_q == 3'b101 ? XLEN'(shifted[15:0])
        : f3_q == 3'b110 ? XLEN'(shifted[31:0]) : shifted;
    timed_out = TIMEOUT != 0 && cnt == 32'(TIMEOUT - 1);
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_n;
  always_comb begin
    state_n = state == IDLE ? (bus.req_valid ? (err != 2'b00 ? RESP : ACCESS) : IDLE)
            : state == ACCESS ? (bus.mem_resp || timed_out ? RESP : ACCESS) : IDLE;
  end
  always_comb begin
    bus.req_ready = state == IDLE;
    bus.resp_valid = state == RESP;
    bus.mem_read = state == ACCESS && !wr_q;
    bus.mem_write = state == ACCESS && wr_q;
  end
  // mem_resp wins over a timeout firing in the same cycle
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      f3_q <= 3'b000;
      wr_q <= 1'b0;
      off_q <= '0;
      cnt <= '0;
      bus.mem_address <= '0;
      bus.mem_wdata <= '0;
      bus.mem_byte_enable <= '0;
      bus.resp_rdata <= '0;
      bus.resp_error <= 2'b00;
    end else if (state == IDLE && bus.req_valid) begin
      f3_q <= bus.req_funct3;
      wr_q <= bus.req_write;
      off_q <= bus.req_addr[OW-1:0];
      cnt <= '0;
      bus.mem_address <= bus.req_addr & ~XLEN'(BW - 1);
      bus.mem_byte_enable <= be_base << bus.req_addr[OW-1:0];
      bus.mem_wdata <= bus.req_write ? rep : '0;
      if (err != 2'b00) begin
        bus.resp_rdata <= '0;
        bus.resp_error <= err;
      end
    end else if (state == ACCESS) begin
      if (bus.mem_resp) begin
        bus.resp_rdata <= wr_q ? '0 : ext;
        bus.resp_error <= 2'b00;
      end else if (timed_out) begin
        bus.resp_rdata <= '0;
        bus.resp_error <= 2'b11;
      end else cnt <= cnt + 32'd1;
    end
endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: table-driven, hand-sequenced and randomized checks of mem_access_unit (XLEN=32, TIMEOUT=4)
module tb_mem_access_unit;
  localparam int TO = 4;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int n_cmp = 0;
  int n_bad = 0;
  mem_access_if #(.XLEN(32)) bus();
  mem_access_unit #(.XLEN(32), .TIMEOUT(TO)) dut (.clk(clk), .rst(rst), .bus(bus.slave));
  always #5 clk = ~clk;
  typedef struct {
    logic wr;
    logic [2:0] f3;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [31:0] rd;
    int k;
    logic [1:0] err;
    logic [31:0] res;
    logic [31:0] ea;
    logic [31:0] ewd;
    logic [3:0] be;
  } vec_t;
  vec_t tbl[15];
  task automatic check(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask
  // reference: size from funct3, legality from the allowed-code lists, data via integer shifts/masks
  function automatic void model(input logic wr, input logic [2:0] f3, input logic [31:0] addr,
                                input logic [31:0] wd, input logic [31:0] rd, input int k,
                                output logic [1:0] err, output logic [31:0] res, output logic [31:0] ea,
                                output logic [31:0] ewd, output logic [3:0] be);
    int n;
    int off;
    bit legal;
    longint v;
    n = 1 << f3[1:0];
    off = int'(addr % 4);
    legal = wr ? (f3 inside {3'd0, 3'd1, 3'd2}) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
    err = !legal ? 2'b10 : (addr % n != 0) ? 2'b01 : (k < 1 || k > TO) ? 2'b11 : 2'b00;
    ea = addr - off;
    be = 4'(((1 << n) - 1) << off);
    for (int i = 0; i < 4; i++) ewd[8*i +: 8] = wd[8*(i % n) +: 8];
    v = (longint'(rd) >> (8 * off)) & ((longint'(1) << (8 * n)) - 1);
    if (!f3[2] && v[8*n-1]) v = v - (longint'(1) << (8 * n));
    res = (err == 2'b00 && !wr) ? 32'(v) : 32'h0;
  endfunction
  // k = cycle (1..) at which mem_resp is driven after acceptance, 0 = never
  task automatic run_txn(input string nm, input logic wr, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wd, input logic [31:0] rd, input int k,
                         input logic [1:0] e_err, input logic [31:0] e_res, input logic [31:0] e_addr,
                         input logic [31:0] e_wd, input logic [3:0] e_be);
    int lat;
    int act;
    int rc;
    logic bad;
    lat = (e_err == 2'b01 || e_err == 2'b10) ? 1 : e_err == 2'b11 ? TO + 1 : k + 1;
    act = 0;
    rc = 0;
    bad = 1'b0;
    check({nm, " req_ready"}, 64'(bus.req_ready), 64'd1);
    bus.req_valid = 1'b1;
    bus.req_write = wr;
    bus.req_funct3 = f3;
    bus.req_addr = addr;
    bus.req_wdata = wd;
    bus.mem_rdata = rd;
    @(negedge clk);
    bus.req_valid = 1'b0;
    bus.req_addr = ~addr;
    bus.req_wdata = ~wd;
    bus.req_funct3 = ~f3;
    for (int c = 1; c <= 12; c++) begin
      bus.mem_resp = (c == k);
      if (bus.mem_read || bus.mem_write) begin
        act++;
        if (bus.mem_write !== wr || bus.mem_read !== !wr || bus.mem_address !== e_addr ||
            bus.mem_byte_enable !== e_be || (wr && bus.mem_wdata !== e_wd)) bad = 1'b1;
      end
      if (bus.resp_valid) begin
        rc = c;
        break;
      end
      @(negedge clk);
    end
    bus.mem_resp = 1'b0;
    check({nm, " resp latency"}, 64'(rc), 64'(lat));
    check({nm, " strobe cycles"}, 64'(act), 64'(lat - 1));
    check({nm, " bus fields"}, 64'(bad), 64'd0);
    check({nm, " resp_error"}, 64'(bus.resp_error), 64'(e_err));
    check({nm, " resp_rdata"}, 64'(bus.resp_rdata), 64'(e_res));
    @(negedge clk);
    check({nm, " resp_valid single"}, 64'(bus.resp_valid), 64'd0);
    check({nm, " rdata hold"}, 64'(bus.resp_rdata), 64'(e_res));
  endtask
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
  initial begin
    logic seen;
    logic wr;
    logic [2:0] f3;
    logic [31:0] addr, wd, rd, res, ea, ewd;
    logic [1:0] err;
    logic [3:0] be;
    int k;
    tbl[0]  = '{1'b0, 3'b000, 32'h1003, 32'h0,        32'h80FF1234, 1, 2'b00, 32'hFFFFFF80, 32'h1000, 32'h0,        4'h8};
    tbl[1]  = '{1'b0, 3'b101, 32'h2002, 32'h0,        32'hBEEF0000, 2, 2'b00, 32'h0000BEEF, 32'h2000, 32'h0,        4'hC};
    tbl[2]  = '{1'b1, 3'b001, 32'h3002, 32'h1234ABCD, 32'h0,        1, 2'b00, 32'h0,        32'h3000, 32'hABCDABCD, 4'hC};
    tbl[3]  = '{1'b0, 3'b010, 32'h4001, 32'h0,        32'h0,        1, 2'b01, 32'h0,        32'h0,    32'h0,        4'h0};
    tbl[4]  = '{1'b0, 3'b011, 32'h4000, 32'h0,        32'h0,        1, 2'b10, 32'h0,        32'h0,    32'h0,        4'h0};
    tbl[5]  = '{1'b0, 3'b010, 32'h5000, 32'h0,        32'h12345678, 0, 2'b11, 32'h0,        32'h5000, 32'h0,        4'hF};
    tbl[6]  = '{1'b0, 3'b010, 32'h6000, 32'h0,        32'h13579BDF, 4, 2'b00, 32'h13579BDF, 32'h6000, 32'h0,        4'hF};
    tbl[7]  = '{1'b1, 3'b000, 32'h7001, 32'h000000A5, 32'h0,        3, 2'b00, 32'h0,        32'h7000, 32'hA5A5A5A5, 4'h2};
    tbl[8]  = '{1'b0, 3'b001, 32'h8000, 32'h0,        32'h00008001, 1, 2'b00, 32'hFFFF8001, 32'h8000, 32'h0,        4'h3};
    tbl[9]  = '{1'b1, 3'b100, 32'h0100, 32'h0,        32'h0,        1, 2'b10, 32'h0,        32'h0,    32'h0,        4'h0};
    tbl[10] = '{1'b0, 3'b111, 32'h0003, 32'h0,        32'h0,        1, 2'b10, 32'h0,        32'h0,    32'h0,        4'h0};
    tbl[11] = '{1'b0, 3'b100, 32'h9001, 32'h0,        32'h0000FF00, 2, 2'b00, 32'h000000FF, 32'h9000, 32'h0,        4'h2};
    tbl[12] = '{1'b1, 3'b010, 32'hA002, 32'h55AA55AA, 32'h0,        1, 2'b01, 32'h0,        32'h0,    32'h0,        4'h0};
    tbl[13] = '{1'b0, 3'b010, 32'hB000, 32'h0,        32'h00000001, 5, 2'b11, 32'h0,        32'hB000, 32'h0,        4'hF};
    tbl[14] = '{1'b1, 3'b010, 32'hC000, 32'hDEADBEEF, 32'h0,        3, 2'b00, 32'h0,        32'hC000, 32'hDEADBEEF, 4'hF};
    bus.req_valid = 1'b0;
    bus.req_write = 1'b0;
    bus.req_funct3 = 3'b000;
    bus.req_addr = '0;
    bus.req_wdata = '0;
    bus.mem_rdata = '0;
    bus.mem_resp = 1'b0;
    repeat (2) @(negedge clk);
    check("reset req_ready", 64'(bus.req_ready), 64'd1);
    check("reset resp_valid", 64'(bus.resp_valid), 64'd0);
    check("reset mem_read", 64'(bus.mem_read), 64'd0);
    check("reset mem_write", 64'(bus.mem_write), 64'd0);
    check("reset resp_rdata", 64'(bus.resp_rdata), 64'd0);
    check("reset resp_error", 64'(bus.resp_error), 64'd0);
    check("reset mem_address", 64'(bus.mem_address), 64'd0);
    check("reset mem_wdata", 64'(bus.mem_wdata), 64'd0);
    check("reset byte_enable", 64'(bus.mem_byte_enable), 64'd0);
    rst = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 15; i++)
      run_txn($sformatf("tbl%0d", i), tbl[i].wr, tbl[i].f3, tbl[i].addr, tbl[i].wd, tbl[i].rd, tbl[i].k,
              tbl[i].err, tbl[i].res, tbl[i].ea, tbl[i].ewd, tbl[i].be);
    // new request held high through ACCESS and RESP must not disturb the one in flight
    bus.mem_rdata = 32'h11223344;
    bus.req_valid = 1'b1;
    bus.req_write = 1'b0;
    bus.req_funct3 = 3'b010;
    bus.req_addr = 32'h1100;
    @(negedge clk);
    bus.req_addr = 32'h2201;
    bus.req_funct3 = 3'b000;
    bus.req_write = 1'b1;
    check("busy req mem_read", 64'(bus.mem_read), 64'd1);
    check("busy req mem_write", 64'(bus.mem_write), 64'd0);
    check("busy req mem_address", 64'(bus.mem_address), 64'h1100);
    check("busy req req_ready", 64'(bus.req_ready), 64'd0);
    bus.mem_resp = 1'b1;
    @(negedge clk);
    bus.mem_resp = 1'b0;
    check("busy req resp_valid", 64'(bus.resp_valid), 64'd1);
    check("busy req resp_rdata", 64'(bus.resp_rdata), 64'h11223344);
    check("busy req mem_read off", 64'(bus.mem_read), 64'd0);
    check("busy req addr held", 64'(bus.mem_address), 64'h1100);
    @(negedge clk);
    bus.req_valid = 1'b0;
    check("busy req idle ready", 64'(bus.req_ready), 64'd1);
    check("busy req idle resp_valid", 64'(bus.resp_valid), 64'd0);
    @(negedge clk);
    check("busy req none accepted", 64'(bus.req_ready), 64'd1);
    check("busy req no strobe", 64'(bus.mem_write), 64'd0);
    // asynchronous reset in the middle of an access
    bus.req_valid = 1'b1;
    bus.req_write = 1'b0;
    bus.req_funct3 = 3'b010;
    bus.req_addr = 32'h5000;
    @(negedge clk);
    bus.req_valid = 1'b0;
    check("rst mid mem_read before", 64'(bus.mem_read), 64'd1);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("rst mid mem_read", 64'(bus.mem_read), 64'd0);
    check("rst mid req_ready", 64'(bus.req_ready), 64'd1);
    check("rst mid resp_valid", 64'(bus.resp_valid), 64'd0);
    check("rst mid resp_rdata", 64'(bus.resp_rdata), 64'd0);
    check("rst mid mem_address", 64'(bus.mem_address), 64'd0);
    check("rst mid byte_enable", 64'(bus.mem_byte_enable), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    bus.mem_resp = 1'b1;
    @(negedge clk);
    bus.mem_resp = 1'b0;
    seen = 1'b0;
    repeat (3) begin
      seen = seen | bus.resp_valid;
      @(negedge clk);
    end
    check("rst mid no resp", 64'(seen), 64'd0);
    // stray mem_resp while idle
    bus.mem_resp = 1'b1;
    @(negedge clk);
    check("idle mem_resp resp_valid", 64'(bus.resp_valid), 64'd0);
    @(negedge clk);
    bus.mem_resp = 1'b0;
    check("idle mem_resp resp_valid 2", 64'(bus.resp_valid), 64'd0);
    check("idle mem_resp ready", 64'(bus.req_ready), 64'd1);
    for (int i = 0; i < 300; i++) begin
      wr = 1'($urandom_range(0, 1));
      f3 = 3'($urandom_range(0, 7));
      addr = $urandom;
      wd = $urandom;
      rd = $urandom;
      k = int'($urandom_range(0, 6));
      model(wr, f3, addr, wd, rd, k, err, res, ea, ewd, be);
      run_txn($sformatf("rnd%0d", i), wr, f3, addr, wd, rd, k, err, res, ea, ewd, be);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
